// File: rtl/debug_dump_tx.sv
// Debug snapshot transmitter: HEADER, PC, register file, data memory over a byte link.
// Optional trailing XOR checksum byte when DUMP_CHECKSUM_EN is defined.
module debug_dump_tx #(
    parameter int         NUM_REGS = 32,
    parameter int         NUM_DM   = 32,
    parameter int         ADDR_W   = 5,
    parameter logic [7:0] HEADER   = 8'hA5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [31:0]       PC,
    output logic [ADDR_W-1:0] RF_ADDR,
    input  logic [31:0]       RF_DATA,
    output logic [ADDR_W-1:0] DM_ADDR,
    input  logic [31:0]       DM_DATA,
    output logic [7:0]        TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PCW,
        S_REGW,
        S_MEMW,
`ifdef DUMP_CHECKSUM_EN
        S_CSUM,
`endif
        S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] REG_LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] DM_LAST  = ADDR_W'(NUM_DM - 1);

    state_t            state, state_d;
    logic [7:0]        tx_data, tx_data_d;
    logic              tx_valid, tx_valid_d;
    logic              busy, busy_d;
    logic              done, done_d;
    logic [ADDR_W-1:0] rf_addr, rf_addr_d;
    logic [ADDR_W-1:0] dm_addr, dm_addr_d;
    logic [ADDR_W-1:0] word_idx, word_idx_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       shreg, shreg_d;
    logic [1:0]        byte_cnt, byte_cnt_d;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        csum, csum_d;
`endif

    logic        xfer;
    logic        last_byte;
    logic        ld;
    logic        sh;
    logic        fin;
    logic [31:0] ld_word;

    assign xfer      = tx_valid & TX_READY;
    assign last_byte = (byte_cnt == 2'd3);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Addresses run one word ahead of the shift register so the next
    // word is already on RF_DATA/DM_DATA when the current one finishes.
    always_comb begin
        state_d    = state;
        busy_d     = busy;
        done_d     = 1'b0;
        rf_addr_d  = rf_addr;
        dm_addr_d  = dm_addr;
        word_idx_d = word_idx;
        pc_d       = pc_q;
        ld         = 1'b0;
        sh         = 1'b0;
        fin        = 1'b0;
        ld_word    = 32'h0;
`ifdef DUMP_CHECKSUM_EN
        csum_d     = csum;
`endif
        unique case (state)
            S_IDLE: begin
                if (START) begin
                    state_d    = S_HDR;
                    pc_d       = PC;
                    busy_d     = 1'b1;
                    word_idx_d = '0;
`ifdef DUMP_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                end
            end
            S_HDR: begin
                if (xfer) begin
                    state_d = S_PCW;
                    ld      = 1'b1;
                    ld_word = pc_q;
                end
            end
            S_PCW: begin
                if (xfer && last_byte) begin
                    state_d    = S_REGW;
                    ld         = 1'b1;
                    ld_word    = RF_DATA;
                    word_idx_d = '0;
                    if (rf_addr != REG_LAST) begin
                        rf_addr_d = rf_addr + 1'b1;
                    end
                end else if (xfer) begin
                    sh = 1'b1;
                end
            end
            S_REGW: begin
                if (xfer && last_byte) begin
                    ld = 1'b1;
                    if (word_idx == REG_LAST) begin
                        state_d    = S_MEMW;
                        ld_word    = DM_DATA;
                        word_idx_d = '0;
                        if (dm_addr != DM_LAST) begin
                            dm_addr_d = dm_addr + 1'b1;
                        end
                    end else begin
                        ld_word    = RF_DATA;
                        word_idx_d = word_idx + 1'b1;
                        if (rf_addr != REG_LAST) begin
                            rf_addr_d = rf_addr + 1'b1;
                        end
                    end
                end else if (xfer) begin
                    sh = 1'b1;
                end
            end
            S_MEMW: begin
                if (xfer && last_byte) begin
                    if (word_idx == DM_LAST) begin
`ifdef DUMP_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        fin     = 1'b1;
`endif
                    end else begin
                        ld         = 1'b1;
                        ld_word    = DM_DATA;
                        word_idx_d = word_idx + 1'b1;
                        if (dm_addr != DM_LAST) begin
                            dm_addr_d = dm_addr + 1'b1;
                        end
                    end
                end else if (xfer) begin
                    sh = 1'b1;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    fin = 1'b1;
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fin) begin
            state_d   = S_FIN;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            rf_addr_d = '0;
            dm_addr_d = '0;
        end
    end

    // Byte datapath: load, shift, or hold the presented byte.
    always_comb begin
        tx_data_d  = tx_data;
        tx_valid_d = tx_valid;
        shreg_d    = shreg;
        byte_cnt_d = byte_cnt;
        if (state == S_IDLE && START) begin
            tx_data_d  = HEADER;
            tx_valid_d = 1'b1;
        end
        if (ld) begin
            shreg_d    = ld_word;
            tx_data_d  = ld_word[31:24];
            byte_cnt_d = 2'd0;
        end else if (sh) begin
            shreg_d    = {shreg[23:0], 8'h00};
            tx_data_d  = shreg[23:16];
            byte_cnt_d = byte_cnt + 2'd1;
        end
`ifdef DUMP_CHECKSUM_EN
        if (state == S_MEMW && state_d == S_CSUM) begin
            tx_data_d = csum ^ tx_data;
        end
`endif
        if (fin) begin
            tx_valid_d = 1'b0;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic payload_xfer;
    logic [7:0] csum_acc;

    assign payload_xfer = xfer && (state == S_PCW ||
                                   state == S_REGW ||
                                   state == S_MEMW);
    assign csum_acc = payload_xfer ? (csum_d ^ tx_data) : csum_d;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rf_addr  <= '0;
            dm_addr  <= '0;
            word_idx <= '0;
            pc_q     <= 32'h0;
            shreg    <= 32'h0;
            byte_cnt <= 2'd0;
`ifdef DUMP_CHECKSUM_EN
            csum     <= 8'h00;
`endif
        end else begin
            tx_data  <= tx_data_d;
            tx_valid <= tx_valid_d;
            busy     <= busy_d;
            done     <= done_d;
            rf_addr  <= rf_addr_d;
            dm_addr  <= dm_addr_d;
            word_idx <= word_idx_d;
            pc_q     <= pc_d;
            shreg    <= shreg_d;
            byte_cnt <= byte_cnt_d;
`ifdef DUMP_CHECKSUM_EN
            csum     <= csum_acc;
`endif
        end
    end

    assign TX_DATA  = tx_data;
    assign TX_VALID = tx_valid;
    assign BUSY     = busy;
    assign DONE     = done;
    assign RF_ADDR  = rf_addr;
    assign DM_ADDR  = dm_addr;

endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx: expected frames queued by stimulus,
// popped and compared by a negedge monitor on each TX transfer.
module tb_debug_dump_tx;

`ifdef DUMP_CHECKSUM_EN
    localparam int FLEN = 262;
`else
    localparam int FLEN = 261;
`endif
    localparam int LIMIT = 20000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [31:0] PC;
    logic [4:0]  RF_ADDR;
    logic [31:0] RF_DATA;
    logic [4:0]  DM_ADDR;
    logic [31:0] DM_DATA;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        BUSY;
    logic        DONE;

    logic [31:0] rf_mem [32];
    logic [31:0] dm_mem [32];
    logic [7:0]  sb [$];
    logic [7:0]  log_b [300];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  frame_bytes = 0;
    int  first_xfer = 0;
    int  last_xfer = 0;
    int  done_cnt = 0;
    bit  rand_mode = 0;
    bit  prev_done = 0;
    bit  held = 0;
    logic [7:0] held_data = 8'h00;

    assign RF_DATA = rf_mem[RF_ADDR];
    assign DM_DATA = dm_mem[DM_ADDR];

    debug_dump_tx dut (
        .CLK(CLK), .RESET(RESET), .START(START), .PC(PC),
        .RF_ADDR(RF_ADDR), .RF_DATA(RF_DATA),
        .DM_ADDR(DM_ADDR), .DM_DATA(DM_DATA),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial forever begin
        @(posedge CLK);
        #1;
        TX_READY = rand_mode ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, hold stability, DONE timing.
    initial forever begin
        logic [7:0] e;
        @(negedge CLK);
        if (RESET && START && !BUSY && !DONE) frame_bytes = 0;
        if (RESET && held)
            chk(TX_VALID && TX_DATA == held_data, "hold",
                {23'h0, TX_VALID, TX_DATA}, {24'h1, held_data});
        held = RESET && TX_VALID && !TX_READY;
        held_data = TX_DATA;
        if (RESET && TX_VALID && TX_READY) begin
            if (sb.size() == 0) begin
                chk(0, "unexpected_byte", TX_DATA, 0);
            end else begin
                e = sb.pop_front();
                chk(TX_DATA == e, $sformatf("byte%0d", frame_bytes),
                    TX_DATA, e);
            end
            if (frame_bytes == 0) first_xfer = cyc;
            if (frame_bytes < 300) log_b[frame_bytes] = TX_DATA;
            frame_bytes++;
            last_xfer = cyc;
        end
        if (RESET && DONE) begin
            done_cnt++;
            chk(!prev_done, "done_width", 2, 1);
            chk(cyc == last_xfer + 1, "done_timing", cyc, last_xfer + 1);
            chk(sb.size() == 0, "sb_empty", sb.size(), 0);
            chk(frame_bytes == FLEN, "frame_len", frame_bytes, FLEN);
            if (!rand_mode)
                chk(last_xfer - first_xfer == FLEN - 1, "no_bubbles",
                    last_xfer - first_xfer, FLEN - 1);
        end
        prev_done = RESET && DONE;
    end

    task automatic push_word(input logic [31:0] w, inout logic [7:0] cs);
        for (int b = 3; b >= 0; b--) begin
            sb.push_back(w[b*8 +: 8]);
            cs ^= w[b*8 +: 8];
        end
    endtask

    task automatic push_frame(input logic [31:0] pcv);
        logic [7:0] cs;
        cs = 8'h00;
        sb.push_back(8'hA5);
        push_word(pcv, cs);
        for (int i = 0; i < 32; i++) push_word(rf_mem[i], cs);
        for (int i = 0; i < 32; i++) push_word(dm_mem[i], cs);
`ifdef DUMP_CHECKSUM_EN
        sb.push_back(cs);
`endif
    endtask

    task automatic run_frame(input logic [31:0] pcv, input bit pc_chg,
                             input int s1, input int s2,
                             input bit fin_start, input int abort_at);
        int d0;
        int n;
        bit p1;
        bit p2;
        push_frame(pcv);
        PC = pcv;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        if (pc_chg) PC = 32'hDEADBEEF;
        d0 = done_cnt;
        n = 0;
        p1 = 0;
        p2 = 0;
        while (done_cnt == d0 && n < LIMIT) begin
            START = 1'b0;
            if (abort_at != 0 && frame_bytes >= abort_at) break;
            if (s1 != 0 && !p1 && frame_bytes >= s1) begin
                START = 1'b1;
                p1 = 1;
            end else if (s2 != 0 && !p2 && frame_bytes >= s2) begin
                START = 1'b1;
                p2 = 1;
            end else if (fin_start && DONE) begin
                START = 1'b1;
            end
            @(posedge CLK);
            #1;
            n++;
        end
        START = 1'b0;
        chk(n < LIMIT, "timeout", n, LIMIT);
    endtask

    initial begin
        int          li [8] = '{0, 4, 8, 12, 133, 136, 140, 260};
        logic [7:0]  lv [8] = '{8'hA5, 8'h40, 8'h00, 8'h01,
                                8'hFF, 8'hFF, 8'hFE, 8'hE0};
        int          d;
        RESET = 1'b0;
        START = 1'b0;
        PC = 32'h0;
        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = 32'h01010101 * i;
            dm_mem[i] = ~32'(i);
        end
        repeat (3) @(posedge CLK);
        #1;
        chk(TX_VALID == 0, "rst_valid", TX_VALID, 0);
        chk(BUSY == 0, "rst_busy", BUSY, 0);
        chk(DONE == 0, "rst_done", DONE, 0);
        chk(TX_DATA == 0, "rst_data", TX_DATA, 0);
        chk(RF_ADDR == 0, "rst_rf_addr", RF_ADDR, 0);
        chk(DM_ADDR == 0, "rst_dm_addr", DM_ADDR, 0);
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        run_frame(32'h40, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            chk(log_b[li[k]] == lv[k], $sformatf("log%0d", li[k]),
                log_b[li[k]], lv[k]);
`ifdef DUMP_CHECKSUM_EN
        chk(log_b[261] == 8'h40, "csum_byte", log_b[261], 8'h40);
`endif

        rand_mode = 1;
        run_frame(32'h40, 0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        rand_mode = 0;
        repeat (2) @(posedge CLK);
        #1;

        d = done_cnt;
        run_frame(32'h40, 0, 10, 200, 1, 0);
        repeat (5) @(posedge CLK);
        #1;
        chk(BUSY == 0, "fin_start_busy", BUSY, 0);
        chk(TX_VALID == 0, "fin_start_valid", TX_VALID, 0);
        chk(done_cnt == d + 1, "single_frame", done_cnt, d + 1);
        chk(RF_ADDR == 0 && DM_ADDR == 0, "addr_ret",
            {RF_ADDR, DM_ADDR}, 0);
        run_frame(32'h40, 0, 0, 0, 0, 0);

        d = done_cnt;
        run_frame(32'h40, 0, 0, 0, 0, 100);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        chk(TX_VALID == 0, "abort_valid", TX_VALID, 0);
        chk(BUSY == 0, "abort_busy", BUSY, 0);
        sb.delete();
        repeat (5) @(posedge CLK);
        #1;
        chk(done_cnt == d, "abort_no_done", done_cnt, d);

        run_frame(32'h40, 1, 0, 0, 0, 0);
        chk({log_b[1], log_b[2], log_b[3], log_b[4]} == 32'h40,
            "pc_capture", {log_b[1], log_b[2], log_b[3], log_b[4]}, 32'h40);

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
